// File: rtl/ip_gf_pkg.sv
// GF(2^8) helpers and FSM state type shared by the Frobenius unit and its lane.
// Field polynomial x^8+x^4+x^3+x+1 (0x11B); GF_POLY holds the low byte.
package ip_gf_pkg;

    localparam int GF_W = 8;
    localparam logic [GF_W-1:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Squaring is linear in GF(2): spread bits to even positions, then reduce.
    function automatic logic [GF_W-1:0] gf_sq8(input logic [GF_W-1:0] a);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[2*i] = a[i];
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'({1'b1, GF_POLY}) << (i - 8));
        end
        return p[GF_W-1:0];
    endfunction

endpackage

// File: rtl/ip_frob_lane.sv
// One Frobenius lane: T' = sq(T) for share 0, T' = L * sq(T) for every other share.
module ip_frob_lane
    import ip_gf_pkg::*;
(
    input  logic [GF_W-1:0] i_t,
    input  logic [GF_W-1:0] i_l,
    input  logic            i_share0,
    output logic [GF_W-1:0] o_t
);

    function automatic logic [GF_W-1:0] gmul8(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
        logic [GF_W-1:0] acc;
        logic [GF_W-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) acc = acc ^ x;
            x = gf_xtime(x);
        end
        return acc;
    endfunction

    logic [GF_W-1:0] w_sq;
    logic [GF_W-1:0] w_prod;

    assign w_sq   = gf_sq8(i_t);
    assign w_prod = gmul8(i_l, w_sq);
    assign o_t    = i_share0 ? w_sq : w_prod;

endmodule

// File: rtl/ip_frobenius_seq.sv
// IPM Frobenius unit: raises an inner-product-masked GF(2^8) value to x^(2^K).
// Define IP_FROBENIUS_PARALLEL_EN for V lanes (one round per cycle); default is one serial lane.
module ip_frobenius_seq
    import ip_gf_pkg::*;
#(
    parameter  int V    = 8,
    parameter  int KMAX = 7,
    localparam int KW   = $clog2(KMAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*V-1:0]   r_in,
    input  logic [8*V-1:0]   l_in,
    input  logic [KW-1:0]    k_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*V-1:0]   t_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [KW:0] KMAX_EXT = (KW+1)'(KMAX);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GF_W-1:0] r_t [V];
    logic [GF_W-1:0] r_l [V];
    logic [KW-1:0]   r_round;
    logic [KW-1:0]   w_k_sat;
    logic            w_last;

    assign w_k_sat = ({1'b0, k_in} > KMAX_EXT) ? KMAX_EXT[KW-1:0] : k_in;

`ifdef IP_FROBENIUS_PARALLEL_EN
    logic [GF_W-1:0] w_lane_t [V];

    for (genvar g = 0; g < V; g++) begin : g_lane
        ip_frob_lane u_lane (
            .i_t      (r_t[g]),
            .i_l      (r_l[g]),
            .i_share0 (g == 0),
            .o_t      (w_lane_t[g])
        );
    end

    assign w_last = (r_round == KW'(1));
`else
    localparam int            IW       = $clog2(V);
    localparam logic [IW-1:0] IDX_LAST = IW'(V - 1);

    logic [IW-1:0]   r_idx;
    logic [GF_W-1:0] w_t_sel;
    logic [GF_W-1:0] w_l_sel;
    logic [GF_W-1:0] w_lane_t;

    // Select one share per cycle; shares are only routed, never combined.
    always_comb begin
        w_t_sel = '0;
        w_l_sel = '0;
        for (int i = 0; i < V; i++) begin
            if (r_idx == IW'(i)) begin
                w_t_sel = r_t[i];
                w_l_sel = r_l[i];
            end
        end
    end

    ip_frob_lane u_lane (
        .i_t      (w_t_sel),
        .i_l      (w_l_sel),
        .i_share0 (r_idx == '0),
        .o_t      (w_lane_t)
    );

    assign w_last = (r_idx == IDX_LAST) && (r_round == KW'(1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (k_in == '0) w_state_nxt = DONE;
                    else            w_state_nxt = RUN;
                end
            end
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= '0;
            for (int i = 0; i < V; i++) begin
                r_t[i] <= '0;
                r_l[i] <= '0;
            end
`ifndef IP_FROBENIUS_PARALLEL_EN
            r_idx <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < V; i++) begin
                            r_t[i] <= r_in[8*i +: 8];
                            r_l[i] <= l_in[8*i +: 8];
                        end
                        r_round <= w_k_sat;
`ifndef IP_FROBENIUS_PARALLEL_EN
                        r_idx <= '0;
`endif
                    end
                end
                RUN: begin
`ifdef IP_FROBENIUS_PARALLEL_EN
                    for (int i = 0; i < V; i++) r_t[i] <= w_lane_t[i];
                    r_round <= r_round - 1'b1;
`else
                    for (int i = 0; i < V; i++) begin
                        if (r_idx == IW'(i)) r_t[i] <= w_lane_t;
                    end
                    if (r_idx == IDX_LAST) begin
                        r_idx   <= '0;
                        r_round <= r_round - 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN);
    assign dbg_state = r_state;

    // Only a finished result is visible; partial rounds never reach the bus.
    always_comb begin
        t_out = '0;
        for (int i = 0; i < V; i++) t_out[8*i +: 8] = out_valid ? r_t[i] : 8'h00;
    end

endmodule

// File: tb/tb_ip_frobenius_seq.sv
// Directed bench for ip_frobenius_seq: a V=2/KMAX=5 instance and a V=8/KMAX=7 instance.
module tb_ip_frobenius_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: V=2, KMAX=5
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_r_in, a_l_in, a_t_out;
    logic [2:0]  a_k_in;
    logic [1:0]  a_dbg_state;

    // Instance B: V=8, KMAX=7
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [63:0] b_r_in, b_l_in, b_t_out;
    logic [2:0]  b_k_in;
    logic [1:0]  b_dbg_state;

    ip_frobenius_seq #(.V(2), .KMAX(5)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .r_in      (a_r_in),
        .l_in      (a_l_in),
        .k_in      (a_k_in),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .t_out     (a_t_out),
        .busy      (a_busy),
        .dbg_state (a_dbg_state)
    );

    ip_frobenius_seq #(.V(8), .KMAX(7)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .r_in      (b_r_in),
        .l_in      (b_l_in),
        .k_in      (b_k_in),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .t_out     (b_t_out),
        .busy      (b_busy),
        .dbg_state (b_dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference field arithmetic: carry-less product then long-division reduction.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_pow(input logic [7:0] a, input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = ref_mul(r, a);
        return r;
    endfunction

    // Closed form: T0 = R0^(2^K), Ti = Li^(2^K-1) * Ri^(2^K).
    function automatic logic [63:0] ref_frob(input logic [63:0] r, input logic [63:0] l, input int k, input int v);
        logic [63:0] t;
        int e;
        t = '0;
        e = 1 << k;
        for (int i = 0; i < v; i++) begin
            if (i == 0) t[8*i +: 8] = ref_pow(r[8*i +: 8], e);
            else        t[8*i +: 8] = ref_mul(ref_pow(l[8*i +: 8], e - 1), ref_pow(r[8*i +: 8], e));
        end
        return t;
    endfunction

    function automatic logic [7:0] ref_ip(input logic [63:0] l, input logic [63:0] t, input int v);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < v; i++) s = s ^ ref_mul(l[8*i +: 8], t[8*i +: 8]);
        return s;
    endfunction

    function automatic int lat_exp(input int k, input int v);
`ifdef IP_FROBENIUS_PARALLEL_EN
        return (k == 0) ? 1 : k + 1;
`else
        return k * v + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge counts as cycle 1; returns edges until out_valid is seen.
    task automatic a_send(input logic [15:0] r, input logic [15:0] l, input logic [2:0] k, output int lat);
        int guard;
        guard = 0;
        while (!a_in_ready && guard < 200) begin tick(); guard++; end
        a_r_in = r; a_l_in = l; a_k_in = k; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 300) begin tick(); lat++; end
    endtask

    task automatic a_take();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic b_send(input logic [63:0] r, input logic [63:0] l, input logic [2:0] k, output int lat);
        int guard;
        guard = 0;
        while (!b_in_ready && guard < 200) begin tick(); guard++; end
        b_r_in = r; b_l_in = l; b_k_in = k; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 300) begin tick(); lat++; end
    endtask

    task automatic b_take();
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] r64, l64, t_exp;
        logic [2:0]  k;

        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_r_in = '0; a_l_in = '0; a_k_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_r_in = '0; b_l_in = '0; b_k_in = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("reset_a_out_valid", a_out_valid, 0);
        check("reset_a_in_ready",  a_in_ready,  1);
        check("reset_a_busy",      a_busy,      0);
        check("reset_a_t_out",     a_t_out,     0);
        check("reset_b_in_ready",  b_in_ready,  1);
        check("reset_b_t_out",     b_t_out,     0);

        // K=1: T0 = 02^2 = 04, T1 = 02 * 03^2 = 0A
        a_send(16'h0302, 16'h0201, 3'd1, lat);
        check("k1_latency", lat, lat_exp(1, 2));
        check("k1_t_out",   a_t_out, 16'h0A04);
        check("k1_ip",      ref_ip(64'(a_l_in), 64'(a_t_out), 2), 8'h10);

        // Hold result under backpressure while a competing request is offered.
        a_r_in = 16'hFFFF; a_k_in = 3'd0; a_in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_out_valid", a_out_valid, 1);
            check("bp_t_out",     a_t_out,     16'h0A04);
            check("bp_in_ready",  a_in_ready,  0);
        end
        a_out_ready = 1'b1;
        tick();
        check("hs_state_idle",  a_dbg_state, 2'd0);
        check("hs_in_ready",    a_in_ready,  1);
        check("hs_out_valid",   a_out_valid, 0);
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;

        // K=2: T0 = 04^2 = 10, T1 = 02 * 0A^2 = 88
        a_send(16'h0302, 16'h0201, 3'd2, lat);
        check("k2_latency", lat, lat_exp(2, 2));
        check("k2_t_out",   a_t_out, 16'h8810);
        check("k2_ip",      ref_ip(64'(a_l_in), 64'(a_t_out), 2), 8'h1B);
        a_take();

        // K=0 pass-through
        a_send(16'hBEEF, 16'h5501, 3'd0, lat);
        check("k0_latency", lat, 1);
        check("k0_t_out",   a_t_out, 16'hBEEF);
        a_take();

        // K=7 exceeds KMAX=5 on instance A and saturates to 5 rounds
        a_send(16'h3A57, 16'h1C01, 3'd7, lat);
        check("sat_latency", lat, lat_exp(5, 2));
        check("sat_t_out",   a_t_out, ref_frob(64'h3A57, 64'h1C01, 5, 2));
        check("sat_ip",      ref_ip(64'h1C01, 64'(a_t_out), 2), ref_pow(ref_ip(64'h1C01, 64'h3A57, 2), 32));
        a_take();

        // Reset during RUN aborts the job
        a_r_in = 16'h0302; a_l_in = 16'h0201; a_k_in = 3'd3; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        check("midrun_busy", a_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", a_out_valid, 0);
        check("abort_in_ready",  a_in_ready,  1);
        check("abort_busy",      a_busy,      0);
        check("abort_t_out",     a_t_out,     0);
        check("abort_state",     a_dbg_state, 2'd0);
        rst = 1'b0;
        tick();
        check("post_abort_idle", a_out_valid, 0);
        a_send(16'h0302, 16'h0201, 3'd2, lat);
        check("post_abort_latency", lat, lat_exp(2, 2));
        check("post_abort_t_out",   a_t_out, 16'h8810);
        a_take();

        // V=8 vectors against the closed-form model
        for (int n = 0; n < 6; n++) begin
            r64 = {$urandom, $urandom};
            l64 = {$urandom, $urandom};
            l64[7:0] = 8'h01;
            if (n == 0)      k = 3'd7;
            else if (n == 1) k = 3'd0;
            else             k = 3'($urandom_range(1, 7));
            t_exp = ref_frob(r64, l64, int'(k), 8);
            b_send(r64, l64, k, lat);
            check("v8_latency", lat, lat_exp(int'(k), 8));
            check("v8_t_out",   b_t_out, t_exp);
            check("v8_ip",      ref_ip(l64, b_t_out, 8), ref_pow(ref_ip(l64, r64, 8), 1 << k));
            b_take();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
